// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the host-side CPU run controller.
// Run FSM states, completion codes and fixed widths.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    RC_IDLE,
    RC_START,
    RC_RUN,
    RC_REPORT
  } run_state;

  typedef enum logic [1:0] {
    RS_OK,
    RS_TIMEOUT,
    RS_ABORT
  } run_status;

  localparam int RUN_CNT_W = 8;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host + CPU facing signal bundle of the run controller.
// master = host/CPU side, slave = controller side.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 16
);
  import cpu_run_ctrl_pkg::*;

  logic                 req;
  logic                 abort;
  logic                 ack;
  logic                 busy;
  logic                 cpu_start;
  logic                 cpu_done;
  logic [CNT_W-1:0]     cycles;
  run_status            status;
  logic [RUN_CNT_W-1:0] run_count;

  modport master (
    output req,
    output abort,
    output cpu_done,
    input  ack,
    input  busy,
    input  cpu_start,
    input  cycles,
    input  status,
    input  run_count
  );

  modport slave (
    input  req,
    input  abort,
    input  cpu_done,
    output ack,
    output busy,
    output cpu_start,
    output cycles,
    output status,
    output run_count
  );

endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// q_inc is the saturated increment, exposed for look-ahead compares.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic [W-1:0] q_inc
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_inc = (&q_q) ? q_q : q_q + 1'b1;
    q_d   = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = q_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: start pulse, cycle count, watchdog.
// All outputs come straight from flops.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int START_W = 2,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int PW = (START_W > 1) ? $clog2(START_W) : 1;

  run_state             state_q, state_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic                 abrt_q, abrt_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  run_status            status_q, status_d;
  logic [RUN_CNT_W-1:0] rc_q, rc_d;

  logic                 cnt_clr;
  logic                 cnt_en;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (cnt),
    .q_inc (cnt_inc)
  );

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    abrt_d   = abrt_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    start_d  = start_q;
    cycles_d = cycles_q;
    status_d = status_q;
    rc_d     = rc_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      RC_IDLE: begin
        ack_d  = 1'b0;
        busy_d = 1'b0;
        if (bus.req) begin
          state_d = RC_START;
          busy_d  = 1'b1;
          start_d = 1'b1;
          pcnt_d  = PW'(START_W - 1);
          abrt_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      RC_START: begin
        if (bus.abort) abrt_d = 1'b1;
        if (pcnt_q == '0) begin
          start_d = 1'b0;
          // a START-phase abort skips RUN once the pulse is complete
          if (abrt_q || bus.abort) begin
            state_d  = RC_REPORT;
            ack_d    = 1'b1;
            cycles_d = cnt;
            status_d = RS_ABORT;
            rc_d     = rc_q + 1'b1;
          end else begin
            state_d = RC_RUN;
          end
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      RC_RUN: begin
        cnt_en = 1'b1;
        if (bus.cpu_done) begin
          state_d  = RC_REPORT;
          status_d = RS_OK;
        end else if (bus.abort) begin
          state_d  = RC_REPORT;
          status_d = RS_ABORT;
        end else if (cnt_inc >= CNT_W'(TIMEOUT)) begin
          state_d  = RC_REPORT;
          status_d = RS_TIMEOUT;
        end
        if (state_d == RC_REPORT) begin
          ack_d    = 1'b1;
          cycles_d = cnt_inc;
          rc_d     = rc_q + 1'b1;
        end
      end
      RC_REPORT: begin
        state_d = RC_IDLE;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = RC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RC_IDLE;
      pcnt_q   <= '0;
      abrt_q   <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      cycles_q <= '0;
      status_q <= RS_OK;
      rc_q     <= '0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      abrt_q   <= abrt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      cycles_q <= cycles_d;
      status_q <= status_d;
      rc_q     <= rc_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_start = start_q;
  assign bus.cycles    = cycles_q;
  assign bus.status    = status_q;
  assign bus.run_count = rc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl (START_W=2, TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int SW  = 2;
  localparam int TO  = 16;
  localparam int CW  = 16;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  cpu_run_ctrl_if #(.CNT_W(CW)) bus ();

  cpu_run_ctrl #(
    .START_W (SW),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run: req pulse, optional abort in first START cycle, then in RUN
  // cycle k drive cpu_done when k==done_at and abort when k==abort_at.
  task automatic do_run(input int done_at, input int abort_at,
                        input bit abort_start,
                        output int hi, output int k);
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    bus.abort = abort_start;
    hi = 0;
    while (bus.cpu_start && hi < 20) begin
      hi++;
      tick();
      bus.abort = 1'b0;
    end
    k = 0;
    while (!bus.ack && k < 200) begin
      k++;
      bus.cpu_done = (k == done_at);
      bus.abort    = (k == abort_at);
      tick();
    end
    bus.cpu_done = 1'b0;
    bus.abort    = 1'b0;
    if (!bus.ack) chk("ack_wait", 0, 1);
  endtask

  task automatic after_ack(input string tag);
    tick();
    chk({tag, "_ack_drop"}, int'(bus.ack), 0);
    chk({tag, "_busy_drop"}, int'(bus.busy), 0);
  endtask

  int hi, k, seen;

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.req = 1'b0;
    bus.abort = 1'b0;
    bus.cpu_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_ack",   int'(bus.ack), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    chk("rst_start", int'(bus.cpu_start), 0);
    chk("rst_cyc",   int'(bus.cycles), 0);
    chk("rst_stat",  int'(bus.status), 0);
    chk("rst_rc",    int'(bus.run_count), 0);

    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    chk("lat_start", int'(bus.cpu_start), 1);
    chk("lat_busy",  int'(bus.busy), 1);
    tick();
    tick();
    bus.cpu_done = 1'b1;
    tick();
    bus.cpu_done = 1'b0;
    chk("lat_ack", int'(bus.ack), 1);
    chk("lat_cyc", int'(bus.cycles), 1);
    after_ack("lat");

    do_run(10, 0, 1'b0, hi, k);
    chk("basic_hi",   hi, 2);
    chk("basic_k",    k, 10);
    chk("basic_cyc",  int'(bus.cycles), 10);
    chk("basic_stat", int'(bus.status), 0);
    chk("basic_rc",   int'(bus.run_count), 2);
    chk("basic_busy", int'(bus.busy), 1);
    after_ack("basic");

    do_run(0, 0, 1'b0, hi, k);
    chk("to_k",    k, TO);
    chk("to_cyc",  int'(bus.cycles), TO);
    chk("to_stat", int'(bus.status), 1);
    chk("to_rc",   int'(bus.run_count), 3);
    after_ack("to");

    do_run(5, 5, 1'b0, hi, k);
    chk("sim5_k",    k, 5);
    chk("sim5_cyc",  int'(bus.cycles), 5);
    chk("sim5_stat", int'(bus.status), 0);
    after_ack("sim5");

    do_run(TO, 0, 1'b0, hi, k);
    chk("simto_cyc",  int'(bus.cycles), TO);
    chk("simto_stat", int'(bus.status), 0);
    chk("simto_rc",   int'(bus.run_count), 5);
    after_ack("simto");

    do_run(0, 3, 1'b0, hi, k);
    chk("abr_k",    k, 3);
    chk("abr_cyc",  int'(bus.cycles), 3);
    chk("abr_stat", int'(bus.status), 2);
    after_ack("abr");

    do_run(0, 0, 1'b1, hi, k);
    chk("abs_hi",   hi, 2);
    chk("abs_k",    k, 0);
    chk("abs_ack",  int'(bus.ack), 1);
    chk("abs_stat", int'(bus.status), 2);
    chk("abs_cyc",  int'(bus.cycles), 0);
    chk("abs_rc",   int'(bus.run_count), 7);
    after_ack("abs");

    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    repeat (5) tick();
    chk("mid_busy_pre", int'(bus.busy), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_start", int'(bus.cpu_start), 0);
    chk("mid_busy",  int'(bus.busy), 0);
    chk("mid_ack",   int'(bus.ack), 0);
    chk("mid_rc",    int'(bus.run_count), 0);
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      tick();
      if (bus.ack) seen++;
    end
    chk("mid_no_ack", seen, 0);

    bus.cpu_done = 1'b1;
    bus.req = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      k = 0;
      while (!bus.ack && k < 50) begin
        k++;
        tick();
      end
      chk("b2b_ack", int'(bus.ack), 1);
      chk("b2b_rc", int'(bus.run_count), r);
      if (r == 3) bus.req = 1'b0;
      tick();
      chk("b2b_idle", int'(bus.busy | bus.cpu_start), 0);
      tick();
      chk("b2b_restart", int'(bus.cpu_start), (r < 3) ? 1 : 0);
    end
    bus.cpu_done = 1'b0;

    for (int r = 0; r < 252; r++) begin
      do_run(1, 0, 1'b0, hi, k);
      tick();
    end
    chk("wrap_255", int'(bus.run_count), 255);
    do_run(2, 0, 1'b0, hi, k);
    chk("wrap_0",     int'(bus.run_count), 0);
    chk("wrap_cyc",   int'(bus.cycles), 2);
    after_ack("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Host-side run controller for the 9-bit CPU top level. It drives the CPU's `start` input and consumes its `done` output, the other end of the start/done run protocol. It accepts run requests from a host over a req/ack handshake and generates a start pulse of programmable width. It then measures execution cycles, enforces a watchdog timeout, and reports completion status with a cycle count and run counter.

## Interface
Parameters:
- `START_W`, default 2: cycles `cpu_start` is held high per run (≥1).
- `TIMEOUT`, default 4096: maximum RUN cycles before forced termination (≥2).
- `CNT_W`, default 16: width of the cycle counter (2^CNT_W > TIMEOUT).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req` in 1: host run request (level).
- `abort` in 1: host abort of the run in progress.
- `ack` out 1: one-cycle pulse; the result fields are valid in this cycle.
- `busy` out 1: high from request acceptance until the `ack` cycle, inclusive.
- `cpu_start` out 1: drives CPU `start`.
- `cpu_done` in 1: CPU `done` (level).
- `cycles` out CNT_W: RUN cycle count of the last run (held until the next `ack`).
- `status` out 2: result of the last run: OK=0, TIMEOUT=1, ABORT=2.
- `run_count` out 8: completed runs; wraps 255→0.

## Operation
States: IDLE, START, RUN, REPORT.
- IDLE: `busy`=0. If `req`=1, go to START, clear the internal counter, and set `busy`=1 next cycle.
- START: `cpu_start`=1 for exactly START_W cycles, then go to RUN. `cpu_done` is ignored here; the CPU clears `done` while `start` is high.
- RUN: `cpu_start`=0. The counter increments every RUN cycle, including the cycle in which the exit condition is sampled. Exit priority, highest first:
  1. `cpu_done`=1 gives status OK.
  2. `abort`=1 gives status ABORT.
  3. The counter reaches TIMEOUT gives status TIMEOUT.
- REPORT, one cycle:
  - `ack`=1.
  - `cycles`, `status` and `run_count`+1 are visible this cycle.
  - Next state is IDLE.
- `abort` in START: finish the current START_W pulse, then go to REPORT with status ABORT. The `cpu_start` pulse is never truncated.
- `req` is sampled only in IDLE. `req` held high after `ack` starts a new run on the cycle after the return to IDLE, giving one IDLE cycle between runs.
- The counter saturates at 2^CNT_W−1 and never wraps.

## Timing
- Reset values:
  - State IDLE.
  - `ack`, `busy`, `cpu_start` = 0.
  - `cycles` = 0, `status` = OK, `run_count` = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency from `req` sampled high to first `cpu_start`=1: 1 cycle.
- `cpu_done` sampled high in RUN cycle N gives `ack` in the next cycle, with `cycles`=N (the first RUN cycle is N=1).
- Timeout: `ack` arrives TIMEOUT+1 cycles after RUN entry, with `cycles`=TIMEOUT.
- Worst-case request-to-ack latency is 1 + START_W + TIMEOUT + 1 cycles.
- Reset mid-run: `cpu_start` drops immediately (asynchronous), no `ack` is produced, and `run_count` is not incremented.

## Structure
- Add to `instr_pack`:
  - `typedef enum logic [1:0] {RC_IDLE, RC_START, RC_RUN, RC_REPORT} run_state;`
  - `typedef enum logic [1:0] {RS_OK, RS_TIMEOUT, RS_ABORT} run_status;`
- One sub-module, `sat_counter`: parameterised width, with synchronous clear, enable, and saturation at all-ones. It is used for the RUN cycle count; the START_W pulse uses a small local down-counter.

## Test plan
- Basic run, START_W=2: `req`=1 for 1 cycle, `cpu_done` rises in the 10th RUN cycle → `cpu_start` high exactly 2 cycles, `ack` 1 cycle later, `cycles`=10, `status`=OK, `run_count`=1.
- Timeout, TIMEOUT=16: `cpu_done` held 0 → `ack` 17 cycles after RUN entry, `cycles`=16, `status`=TIMEOUT.
- Simultaneous events: `cpu_done`=1 and `abort`=1 in RUN cycle 5, and in a separate run `cpu_done` arrives on cycle TIMEOUT → `status`=OK both times.
- Abort during START: `abort`=1 in the first START cycle → `cpu_start` still high 2 cycles, then REPORT with `status`=ABORT.
- Back-to-back requests: `req` held high for 3 runs → three `ack` pulses with exactly 1 IDLE cycle between REPORT and the next START, and `run_count`=3. With `run_count` preloaded by 255 runs, the next run wraps it to 0.
- Asynchronous reset asserted mid-RUN → `cpu_start`, `busy` and `ack` are 0 without waiting for a clock edge, and no `ack` follows reset release.
